// File: rtl/trig_seq_pkg.sv
// trig_seq_pkg: shared state encoding and default sizing for the capture sequencer
package trig_seq_pkg;
  typedef enum logic [2:0] {
    IDLE,
    PRETRIG,
    ARMED,
    POSTTRIG,
    DONE
  } state_t;
  localparam int ADDR_W_DEF = 9;
  // capture states in which sample strobes are written to RAM
  function automatic logic is_capturing(input state_t s);
    return (s == PRETRIG) || (s == ARMED) || (s == POSTTRIG);
  endfunction
endpackage

// File: rtl/trig_qual.sv
// trig_qual: qualifies protocol/channel triggers with enables and edge-detects the result
module trig_qual (
  input  logic clk,
  input  logic rst,
  input  logic protTrig,
  input  logic chTrig,
  input  logic prot_en,
  input  logic ch_en,
  input  logic force_trig,
  output logic trig_evt
);
  logic w_trig_in;
  logic r_trig_q;
  assign w_trig_in = (protTrig | ~prot_en) & (chTrig | ~ch_en) & (prot_en | ch_en);
  // previous qualified level so only a rising edge counts as a trigger
  always_ff @(posedge clk) begin
    if (rst) r_trig_q <= 1'b0;
    else r_trig_q <= w_trig_in;
  end
  assign trig_evt = (w_trig_in & ~r_trig_q) | force_trig;
endmodule

// File: rtl/trig_seq.sv
// trig_seq: capture sequencer driving sample-RAM writes, trigger address and status
module trig_seq
  import trig_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic              clr_done,
  input  logic              smpl_en,
  input  logic              protTrig,
  input  logic              chTrig,
  input  logic              prot_en,
  input  logic              ch_en,
  input  logic              force_trig,
  input  logic [ADDR_W-1:0] trig_pos,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              armed,
  output logic              triggered,
  output logic              capture_done
);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_waddr, r_trig_addr, r_post_cnt, w_post_inc;
  logic [ADDR_W:0] r_pre_cnt, w_pre_inc, w_pre_tgt;
  logic r_triggered, w_trig_evt, w_start, w_accept;
  trig_qual u_qual (
    .clk(clk),
    .rst(rst),
    .protTrig(protTrig),
    .chTrig(chTrig),
    .prot_en(prot_en),
    .ch_en(ch_en),
    .force_trig(force_trig),
    .trig_evt(w_trig_evt)
  );
  assign w_pre_inc  = r_pre_cnt + (ADDR_W + 1)'(1);
  assign w_pre_tgt  = DEPTH - {1'b0, trig_pos};
  assign w_post_inc = r_post_cnt + ADDR_W'(1);
  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  // next state: abort beats arm, arm restarts from any state, then per-state progress
  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    w_accept = 1'b0;
    if (abort) w_next = IDLE;
    else if (arm) begin
      w_next  = PRETRIG;
      w_start = 1'b1;
    end else begin
      case (r_state)
        PRETRIG:  w_next = (smpl_en && w_pre_inc == w_pre_tgt) ? ARMED : PRETRIG;
        ARMED: begin
          w_accept = w_trig_evt;
          w_next   = !w_trig_evt ? ARMED : (trig_pos == '0) ? DONE : POSTTRIG;
        end
        POSTTRIG: w_next = (smpl_en && w_post_inc == trig_pos) ? DONE : POSTTRIG;
        DONE:     w_next = clr_done ? IDLE : DONE;
        default:  w_next = IDLE;
      endcase
    end
  end
  // write pointer, fill counters and trigger bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_waddr     <= '0;
      r_trig_addr <= '0;
      r_pre_cnt   <= '0;
      r_post_cnt  <= '0;
      r_triggered <= 1'b0;
    end else if (abort) begin
      r_triggered <= 1'b0;
      if (we) r_waddr <= r_waddr + ADDR_W'(1);
    end else if (w_start) begin
      r_waddr     <= '0;
      r_pre_cnt   <= '0;
      r_post_cnt  <= '0;
      r_triggered <= 1'b0;
    end else begin
      if (we) r_waddr <= r_waddr + ADDR_W'(1);
      if (r_state == PRETRIG && smpl_en) r_pre_cnt <= w_pre_inc;
      if (r_state == POSTTRIG && smpl_en) r_post_cnt <= w_post_inc;
      if (w_accept) begin
        r_triggered <= 1'b1;
        r_trig_addr <= r_waddr + ADDR_W'(smpl_en);
      end
    end
  end
  assign we           = smpl_en & is_capturing(r_state);
  assign waddr        = r_waddr;
  assign trig_addr    = r_trig_addr;
  assign armed        = r_state == ARMED;
  assign triggered    = r_triggered;
  assign capture_done = r_state == DONE;
endmodule

// File: tb/tb_trig_seq.sv
// tb_trig_seq: directed checks of the capture sequencer at ADDR_W=4
module tb_trig_seq;
  logic clk = 1'b0;
  logic rst, arm, abort, clr_done, smpl_en, protTrig, chTrig, prot_en, ch_en, force_trig;
  logic [3:0] trig_pos, waddr, trig_addr;
  logic we, armed, triggered, capture_done;
  int n_chk = 0;
  int n_fail = 0;
  trig_seq #(.ADDR_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .arm(arm),
    .abort(abort),
    .clr_done(clr_done),
    .smpl_en(smpl_en),
    .protTrig(protTrig),
    .chTrig(chTrig),
    .prot_en(prot_en),
    .ch_en(ch_en),
    .force_trig(force_trig),
    .trig_pos(trig_pos),
    .we(we),
    .waddr(waddr),
    .trig_addr(trig_addr),
    .armed(armed),
    .triggered(triggered),
    .capture_done(capture_done)
  );
  always #5 clk = ~clk;
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1; arm = 0; abort = 0; clr_done = 0; smpl_en = 1; protTrig = 0; chTrig = 0;
    prot_en = 1; ch_en = 0; force_trig = 0; trig_pos = 4;
    cyc(2); #1;
    chk("rst_we", 32'(we), 0);
    chk("rst_waddr", 32'(waddr), 0);
    chk("rst_trig_addr", 32'(trig_addr), 0);
    chk("rst_armed", 32'(armed), 0);
    chk("rst_triggered", 32'(triggered), 0);
    chk("rst_done", 32'(capture_done), 0);
    rst = 0;
    cyc(1); arm = 1; #1;
    chk("idle_we", 32'(we), 0);
    cyc(1); arm = 0; #1;
    chk("pre_we", 32'(we), 1);
    chk("pre_waddr0", 32'(waddr), 0);
    chk("pre_armed", 32'(armed), 0);
    cyc(4); protTrig = 1; #1;
    chk("pre_waddr4", 32'(waddr), 4);
    cyc(1); protTrig = 0;
    cyc(6); #1;
    chk("pre_waddr11", 32'(waddr), 11);
    chk("pre_not_armed", 32'(armed), 0);
    cyc(1); #1;
    chk("armed_t13", 32'(armed), 1);
    chk("armed_waddr", 32'(waddr), 12);
    chk("pre_pulse_ignored", 32'(triggered), 0);
    cyc(7); protTrig = 1; #1;
    chk("trig_cycle_waddr", 32'(waddr), 3);
    cyc(1); protTrig = 0; #1;
    chk("norm_triggered", 32'(triggered), 1);
    chk("norm_trig_addr", 32'(trig_addr), 4);
    chk("post_waddr4", 32'(waddr), 4);
    chk("post_not_armed", 32'(armed), 0);
    cyc(3); #1;
    chk("post_waddr7", 32'(waddr), 7);
    chk("post_we", 32'(we), 1);
    chk("post_not_done", 32'(capture_done), 0);
    cyc(1); #1;
    chk("done_flag", 32'(capture_done), 1);
    chk("done_we", 32'(we), 0);
    arm = 1; clr_done = 1;
    cyc(1); arm = 0; clr_done = 0; #1;
    chk("armclr_done", 32'(capture_done), 0);
    chk("armclr_waddr", 32'(waddr), 0);
    chk("armclr_we", 32'(we), 1);
    chk("armclr_triggered", 32'(triggered), 0);
    cyc(12); force_trig = 1; #1;
    chk("c2_armed", 32'(armed), 1);
    chk("c2_waddr", 32'(waddr), 12);
    cyc(1); force_trig = 0; #1;
    chk("c2_triggered", 32'(triggered), 1);
    chk("c2_trig_addr", 32'(trig_addr), 13);
    cyc(1); abort = 1;
    cyc(1); abort = 0; #1;
    chk("abort_we", 32'(we), 0);
    chk("abort_triggered", 32'(triggered), 0);
    chk("abort_armed", 32'(armed), 0);
    chk("abort_trig_addr", 32'(trig_addr), 13);
    protTrig = 1; arm = 1;
    cyc(1); arm = 0;
    cyc(15); #1;
    chk("lvl_armed", 32'(armed), 1);
    chk("lvl_no_trig", 32'(triggered), 0);
    protTrig = 0;
    cyc(2); protTrig = 1; #1;
    chk("lvl_waddr", 32'(waddr), 1);
    cyc(1); #1;
    chk("lvl_triggered", 32'(triggered), 1);
    chk("lvl_trig_addr", 32'(trig_addr), 2);
    cyc(1); rst = 1;
    cyc(1); rst = 0; protTrig = 0; #1;
    chk("mid_rst_we", 32'(we), 0);
    chk("mid_rst_waddr", 32'(waddr), 0);
    chk("mid_rst_trig_addr", 32'(trig_addr), 0);
    chk("mid_rst_armed", 32'(armed), 0);
    chk("mid_rst_triggered", 32'(triggered), 0);
    chk("mid_rst_done", 32'(capture_done), 0);
    trig_pos = 0; arm = 1;
    cyc(1); arm = 0;
    cyc(15); #1;
    chk("tp0_pre_armed", 32'(armed), 0);
    chk("tp0_pre_waddr", 32'(waddr), 15);
    cyc(1); #1;
    chk("tp0_armed", 32'(armed), 1);
    chk("tp0_wrap_waddr", 32'(waddr), 0);
    cyc(1); force_trig = 1; #1;
    chk("tp0_force_waddr", 32'(waddr), 1);
    cyc(1); force_trig = 0; #1;
    chk("tp0_done", 32'(capture_done), 1);
    chk("tp0_we", 32'(we), 0);
    chk("tp0_triggered", 32'(triggered), 1);
    chk("tp0_trig_addr", 32'(trig_addr), 2);
    chk("tp0_no_post_write", 32'(waddr), 2);
    trig_pos = 4; prot_en = 0; arm = 1;
    cyc(1); arm = 0;
    cyc(13); protTrig = 1;
    cyc(1); protTrig = 0; #1;
    chk("noen_armed", 32'(armed), 1);
    chk("noen_no_trig", 32'(triggered), 0);
    cyc(1); force_trig = 1; smpl_en = 0; #1;
    chk("noen_idle_we", 32'(we), 0);
    chk("noen_waddr", 32'(waddr), 15);
    cyc(1); force_trig = 0; smpl_en = 1; #1;
    chk("noen_force_trig", 32'(triggered), 1);
    chk("noen_trig_addr", 32'(trig_addr), 15);
    chk("noen_post", 32'(armed), 0);
    cyc(4); #1;
    chk("noen_done", 32'(capture_done), 1);
    chk("noen_final_waddr", 32'(waddr), 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
